// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port IDs.
package mem_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_DONE  = S_DONE
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the byte memory macro.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_done;
    logic [DW-1:0] c_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          d_lock;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        output c_done, c_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        input  c_done, c_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational 2-way round-robin picker: a tie goes to the port that did not own the last access.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_c,
    input  logic i_req_d,
    input  logic i_last_owner,
    output logic o_grant_valid,
    output logic o_grant_id
);

    // grant selection
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = PORT_C;
        if (i_req_c && i_req_d) begin
            o_grant_valid = 1'b1;
            o_grant_id    = ~i_last_owner;
        end else if (i_req_c) begin
            o_grant_valid = 1'b1;
            o_grant_id    = PORT_C;
        end else if (i_req_d) begin
            o_grant_valid = 1'b1;
            o_grant_id    = PORT_D;
        end else begin
            o_grant_valid = 1'b0;
            o_grant_id    = PORT_C;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU (C) and debug loader (D) accesses onto one byte memory with fixed read latency.
// All outputs are registered from the next-state decode so they line up with the FSM state.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_cnt;
    logic          r_owner;
    logic          r_last_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_busy;
    logic          r_c_done;
    logic          r_d_done;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_req_c;
    logic          w_grant_valid;
    logic          w_grant_id;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // the lock only holds off new CPU grants; D is never masked
    assign w_req_c = bus.c_req & ~bus.d_lock;

    mem_arb_pick u_pick (
        .i_req_c       (w_req_c),
        .i_req_d       (bus.d_req),
        .i_last_owner  (r_last_owner),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // request fields of the port being granted
    always_comb begin
        w_sel_we    = bus.c_we;
        w_sel_addr  = bus.c_addr;
        w_sel_wdata = bus.c_wdata;
        if (w_grant_id == PORT_D) begin
            w_sel_we    = bus.d_we;
            w_sel_addr  = bus.d_addr;
            w_sel_wdata = bus.d_wdata;
        end else begin
            w_sel_we    = bus.c_we;
            w_sel_addr  = bus.c_addr;
            w_sel_wdata = bus.c_wdata;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) w_next = ST_ISSUE;
                else               w_next = ST_IDLE;
            end
            ST_ISSUE: begin
                if (r_we) w_next = ST_DONE;
                else      w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) w_next = ST_DONE;
                else               w_next = ST_WAIT;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // state, access latches, latency counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_owner      <= PORT_C;
            r_last_owner <= PORT_D;
            r_we         <= 1'b0;
            r_addr       <= {AW{1'b0}};
            r_wdata      <= {DW{1'b0}};
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_c_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_c_rdata    <= {DW{1'b0}};
            r_d_rdata    <= {DW{1'b0}};
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_grant_valid) begin
                r_owner <= w_grant_id;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == ST_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            // read byte lands in the owner's rdata register on the way into DONE
            if (r_state == ST_WAIT && r_cnt == 2'd0) begin
                if (r_owner == PORT_D) r_d_rdata <= bus.mem_rdata;
                else                   r_c_rdata <= bus.mem_rdata;
            end
            if (r_state == ST_DONE) begin
                r_last_owner <= r_owner;
            end
            r_mem_en <= (w_next == ST_ISSUE);
            r_mem_we <= (w_next == ST_ISSUE) && w_sel_we;
            r_busy   <= (w_next != ST_IDLE);
            r_c_done <= (w_next == ST_DONE) && (r_owner == PORT_C);
            r_d_done <= (w_next == ST_DONE) && (r_owner == PORT_D);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;
    assign bus.c_done    = r_c_done;
    assign bus.d_done    = r_d_done;
    assign bus.c_rdata   = r_c_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level timing model compared every cycle,
// plus literal checks; extra RD_LAT=1 and RD_LAT=4 instances cover read latency.
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(8), .DW(8)) u_if  ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) u_if1 ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) u_if4 ();

    mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if.slave));
    mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
    mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(u_if4.slave));

    // main memory: data valid exactly RD_LAT cycles after the issue cycle, 8'hEE otherwise
    logic [7:0] mem [256];
    logic [1:0] pv;
    logic [7:0] pa [2];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
            mem[8'h10] <= 8'hA5;
            mem[8'h44] <= 8'h7E;
            pv <= 2'b00;
        end else begin
            if (u_if.mem_en && u_if.mem_we) mem[u_if.mem_addr] <= u_if.mem_wdata;
            pv <= {pv[0], u_if.mem_en & ~u_if.mem_we};
        end
        pa[0] <= u_if.mem_addr;
        pa[1] <= pa[0];
    end
    assign u_if.mem_rdata = pv[1] ? mem[pa[1]] : 8'hEE;

    // latency-1 and latency-4 memories return addr ^ 8'h5A only in the valid cycle
    logic       q1v;
    logic [7:0] q1a;
    logic [3:0] q4v;
    logic [31:0] q4a;
    always @(posedge clk) begin
        if (!rst_n) begin
            q1v <= 1'b0;
            q4v <= 4'd0;
        end else begin
            q1v <= u_if1.mem_en & ~u_if1.mem_we;
            q4v <= {q4v[2:0], u_if4.mem_en & ~u_if4.mem_we};
        end
        q1a <= u_if1.mem_addr;
        q4a <= {q4a[23:0], u_if4.mem_addr};
    end
    assign u_if1.mem_rdata = q1v ? (q1a ^ 8'h5A) : 8'hEE;
    assign u_if4.mem_rdata = q4v[3] ? (q4a[31:24] ^ 8'h5A) : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // transaction model: a grant at cycle t0 issues at t0+1 and completes at t0+dur
    logic       m_active, m_last, m_port, m_we;
    logic [7:0] m_addr, m_wdata, m_rd;
    int         m_t0;
    logic       e_mem_en, e_mem_we, e_busy, e_owner, e_cd, e_dd;
    logic [7:0] e_addr, e_wdata, e_crd, e_drd;

    initial begin : compare
        int   k;
        int   dur;
        logic cr;
        logic dr;
        forever begin
            @(negedge clk);
            e_mem_en = 1'b0; e_mem_we = 1'b0; e_busy = 1'b0; e_cd = 1'b0; e_dd = 1'b0;
            k = 0; dur = 0;
            if (!rst_n) begin
                m_active = 1'b0; m_last = 1'b1;
                e_addr = 8'h00; e_wdata = 8'h00; e_owner = 1'b0; e_crd = 8'h00; e_drd = 8'h00;
            end else if (m_active) begin
                k   = cyc - m_t0;
                dur = m_we ? 2 : 2 + RD_LAT;
                e_busy = 1'b1;
                if (k == 1) begin
                    e_mem_en = 1'b1; e_mem_we = m_we;
                    e_addr = m_addr; e_wdata = m_wdata; e_owner = m_port;
                    m_rd = mem[m_addr];
                end
                if (k == dur) begin
                    if (m_port) e_dd = 1'b1; else e_cd = 1'b1;
                    if (!m_we) begin
                        if (m_port) e_drd = m_rd; else e_crd = m_rd;
                    end
                end
            end
            chk("mem_en",    u_if.mem_en,    e_mem_en);
            chk("mem_we",    u_if.mem_we,    e_mem_we);
            chk("mem_addr",  u_if.mem_addr,  e_addr);
            chk("mem_wdata", u_if.mem_wdata, e_wdata);
            chk("busy",      u_if.busy,      e_busy);
            chk("owner",     u_if.owner,     e_owner);
            chk("c_done",    u_if.c_done,    e_cd);
            chk("d_done",    u_if.d_done,    e_dd);
            chk("c_rdata",   u_if.c_rdata,   e_crd);
            chk("d_rdata",   u_if.d_rdata,   e_drd);
            if (rst_n) begin
                if (m_active) begin
                    if (k == dur) begin
                        m_active = 1'b0;
                        m_last   = m_port;
                    end
                end else begin
                    cr = u_if.c_req && !u_if.d_lock;
                    dr = u_if.d_req;
                    if (cr || dr) begin
                        m_port   = (cr && dr) ? ~m_last : dr;
                        m_we     = m_port ? u_if.d_we    : u_if.c_we;
                        m_addr   = m_port ? u_if.d_addr  : u_if.c_addr;
                        m_wdata  = m_port ? u_if.d_wdata : u_if.c_wdata;
                        m_t0     = cyc;
                        m_active = 1'b1;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int         n_c;
        int         n_d;
        logic [3:0] seq;
        int         t1, t4, n1, n4;
        logic [7:0] r1, r4;

        u_if.c_req = 1'b0; u_if.c_we = 1'b0; u_if.c_addr = 8'h00; u_if.c_wdata = 8'h00;
        u_if.d_req = 1'b0; u_if.d_we = 1'b0; u_if.d_addr = 8'h00; u_if.d_wdata = 8'h00;
        u_if.d_lock = 1'b0;
        u_if1.c_req = 1'b0; u_if1.c_we = 1'b0; u_if1.c_addr = 8'h00; u_if1.c_wdata = 8'h00;
        u_if1.d_req = 1'b0; u_if1.d_we = 1'b0; u_if1.d_addr = 8'h00; u_if1.d_wdata = 8'h00;
        u_if1.d_lock = 1'b0;
        u_if4.c_req = 1'b0; u_if4.c_we = 1'b0; u_if4.c_addr = 8'h00; u_if4.c_wdata = 8'h00;
        u_if4.d_req = 1'b0; u_if4.d_we = 1'b0; u_if4.d_addr = 8'h00; u_if4.d_wdata = 8'h00;
        u_if4.d_lock = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", u_if.busy, 1'b0);
        chk("reset_owner", u_if.owner, 1'b0);
        rst_n = 1'b1;

        // 1: reset during WAIT abandons the read
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 8'h55;
        next_cycle();
        next_cycle();
        chk("t1_busy_in_wait", u_if.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_mem_en", u_if.mem_en, 1'b0);
        chk("t1_rst_busy", u_if.busy, 1'b0);
        u_if.c_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (u_if.c_done) n_c++;
        end
        chk("t1_no_done", n_c, 0);
        next_cycle();

        // 2: C read of 8'h10 returns 8'hA5 at cycle 4
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 8'h10;
        wait_neg(1);
        chk("t2_mem_en", u_if.mem_en, 1'b1);
        chk("t2_mem_we", u_if.mem_we, 1'b0);
        chk("t2_mem_addr", u_if.mem_addr, 8'h10);
        wait_neg(3);
        chk("t2_c_done", u_if.c_done, 1'b1);
        chk("t2_c_rdata", u_if.c_rdata, 8'hA5);
        next_cycle();
        u_if.c_req = 1'b0;
        next_cycle();

        // 3: D write 8'h3C to 8'h20, done at cycle 2
        u_if.d_req = 1'b1; u_if.d_we = 1'b1; u_if.d_addr = 8'h20; u_if.d_wdata = 8'h3C;
        wait_neg(1);
        chk("t3_mem_en", u_if.mem_en, 1'b1);
        chk("t3_mem_we", u_if.mem_we, 1'b1);
        chk("t3_mem_addr", u_if.mem_addr, 8'h20);
        chk("t3_mem_wdata", u_if.mem_wdata, 8'h3C);
        wait_neg(1);
        chk("t3_d_done", u_if.d_done, 1'b1);
        chk("t3_c_done", u_if.c_done, 1'b0);
        next_cycle();
        u_if.d_req = 1'b0;

        // 4: both request writes continuously after reset -> C,D,C,D
        do_reset();
        u_if.c_req = 1'b1; u_if.c_we = 1'b1; u_if.c_addr = 8'h30; u_if.c_wdata = 8'h11;
        u_if.d_req = 1'b1; u_if.d_we = 1'b1; u_if.d_addr = 8'h31; u_if.d_wdata = 8'h22;
        seq = 4'd0; n_c = 0; n_d = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.c_done) begin n_c++; seq = {seq[2:0], 1'b0}; end
            if (u_if.d_done) begin n_d++; seq = {seq[2:0], 1'b1}; end
        end
        chk("t4_order", seq, 4'b0101);
        chk("t4_n_c", n_c, 2);
        chk("t4_n_d", n_d, 2);
        next_cycle();

        // 5: lock lets only D through; C wins once the lock drops
        u_if.d_lock = 1'b1;
        u_if.c_addr = 8'h40; u_if.d_addr = 8'h41;
        n_c = 0; n_d = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (u_if.c_done) n_c++;
            if (u_if.d_done) n_d++;
        end
        chk("t5_lock_c", n_c, 0);
        chk("t5_lock_d", n_d, 3);
        next_cycle();
        u_if.d_lock = 1'b0;
        wait_neg(1);
        chk("t5_owner_c", u_if.owner, 1'b0);
        chk("t5_addr_c", u_if.mem_addr, 8'h40);
        wait_neg(1);
        chk("t5_c_done", u_if.c_done, 1'b1);
        next_cycle();
        u_if.c_req = 1'b0; u_if.d_req = 1'b0;
        next_cycle();
        u_if.c_req = 1'b1; u_if.c_we = 1'b0; u_if.c_addr = 8'h44;
        next_cycle();
        next_cycle();
        u_if.d_lock = 1'b1;
        wait_neg(2);
        chk("t5_locked_read_done", u_if.c_done, 1'b1);
        chk("t5_locked_read_data", u_if.c_rdata, 8'h7E);
        next_cycle();
        u_if.c_req = 1'b0; u_if.d_lock = 1'b0;
        next_cycle();

        // 6: RD_LAT=1 / RD_LAT=4 reads, request dropped during WAIT
        u_if1.c_req = 1'b1; u_if1.c_we = 1'b0; u_if1.c_addr = 8'h33;
        u_if4.c_req = 1'b1; u_if4.c_we = 1'b0; u_if4.c_addr = 8'h33;
        t1 = -1; t4 = -1; n1 = 0; n4 = 0; r1 = 8'h00; r4 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (u_if1.c_done) begin t1 = i; n1++; r1 = u_if1.c_rdata; end
            if (u_if4.c_done) begin t4 = i; n4++; r4 = u_if4.c_rdata; end
            next_cycle();
            if (i == 1) begin
                u_if1.c_req = 1'b0;
                u_if4.c_req = 1'b0;
            end
        end
        chk("t6_lat1_cycle", t1, 3);
        chk("t6_lat1_data", r1, 8'h69);
        chk("t6_lat1_count", n1, 1);
        chk("t6_lat4_cycle", t4, 6);
        chk("t6_lat4_data", r4, 8'h69);
        chk("t6_lat4_count", n4, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
